// File: rtl/calc_keys_pkg.sv
// Shared key-code constants, FSM encoding and operator decode for the keypad-to-CU path.
package calc_keys_pkg;

  localparam logic [3:0] KEY_SUBMIT   = 4'hF;
  localparam logic [3:0] KEY_OPT_BASE = 4'hA;
  localparam int         OPT_W        = 3;
  localparam int         NUM_W        = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  // Operator keys A..E map onto CU operator codes 1..5.
  function automatic logic [OPT_W-1:0] opt_of(input logic [3:0] code);
    logic [3:0] diff;
    diff = code - (KEY_OPT_BASE - 4'd1);
    return diff[OPT_W-1:0];
  endfunction

endpackage

// File: rtl/key_fifo.sv
// Synchronous DEPTH x W FIFO; full/empty are registered and next-state flags are exported
// so the owner can register status outputs that line up with the flags.
module key_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic         full_nxt,
  output logic         empty_nxt
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full_q, empty_q;
  logic          do_push, do_pop;

  // Pointer and occupancy next-state; a full FIFO refuses a push even if a pop happens this cycle.
  always_comb begin
    do_push  = push & ~full_q & ~clr;
    do_pop   = pop & ~empty_q & ~clr;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
    full_nxt  = (count_d == (AW+1)'(DEPTH));
    empty_nxt = (count_d == '0);
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_nxt;
      empty_q  <= empty_nxt;
    end
  end

  // Storage array; contents are only meaningful while not empty.
  always_ff @(posedge clk) begin
    if (reset && do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/key_event_sequencer.sv
// Buffers keypad codes and replays them to the CU as single, non-overlapping strobes
// separated by a guaranteed idle gap (longer after submit to cover CU compute time).
module key_event_sequencer
  import calc_keys_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int PULSE_CYC  = 2,
  parameter int GAP_CYC    = 2,
  parameter int SUBMIT_GAP = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  input  logic             flush,
  output logic             key_ready,
  output logic             overflow,
  output logic             busy,
  output logic [NUM_W-1:0] num,
  output logic             numPressed,
  output logic [OPT_W-1:0] opt,
  output logic             optPressed,
  output logic             submit
);

  localparam logic [7:0] PULSE_LD  = 8'(PULSE_CYC - 1);
  localparam logic [7:0] GAP_LD    = 8'(GAP_CYC - 1);
  localparam logic [7:0] SUBMIT_LD = 8'(SUBMIT_GAP - 1);

  logic [1:0]       state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [NUM_W-1:0] num_q, num_d;
  logic [OPT_W-1:0] opt_q, opt_d;
  logic             np_q, np_d, op_q, op_d, sub_q, sub_d;
  logic             ovf_q, ovf_d, rdy_q, rdy_d, busy_q, busy_d;

  logic [3:0] fifo_dout;
  logic       fifo_full, fifo_empty, fifo_full_nxt, fifo_empty_nxt, fifo_pop;

  assign fifo_pop = (state_q == ST_IDLE) & ~fifo_empty & ~flush;

  key_fifo #(.DEPTH(DEPTH), .W(4)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clr       (flush),
    .push      (key_valid),
    .pop       (fifo_pop),
    .din       (key_code),
    .dout      (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .full_nxt  (fifo_full_nxt),
    .empty_nxt (fifo_empty_nxt)
  );

  // Command FSM, decode and status next-state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    opt_d   = opt_q;
    np_d    = np_q;
    op_d    = op_q;
    sub_d   = sub_q;
    ovf_d   = ovf_q;
    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = 8'd0;
      num_d   = '0;
      opt_d   = '0;
      np_d    = 1'b0;
      op_d    = 1'b0;
      sub_d   = 1'b0;
      ovf_d   = 1'b0;
    end else begin
      ovf_d = ovf_q | (key_valid & fifo_full);
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            state_d = ST_ISSUE;
            cnt_d   = PULSE_LD;
            if (fifo_dout == KEY_SUBMIT) begin
              sub_d = 1'b1;
            end else if (fifo_dout >= KEY_OPT_BASE) begin
              op_d  = 1'b1;
              opt_d = opt_of(fifo_dout);
            end else begin
              np_d  = 1'b1;
              num_d = fifo_dout;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_ISSUE: begin
          if (cnt_q == 8'd0) begin
            state_d = ST_GAP;
            cnt_d   = sub_q ? SUBMIT_LD : GAP_LD;
            num_d   = '0;
            opt_d   = '0;
            np_d    = 1'b0;
            op_d    = 1'b0;
            sub_d   = 1'b0;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        ST_GAP: begin
          if (cnt_q == 8'd0) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
          num_d   = '0;
          opt_d   = '0;
          np_d    = 1'b0;
          op_d    = 1'b0;
          sub_d   = 1'b0;
        end
      endcase
    end
    rdy_d  = ~fifo_full_nxt;
    busy_d = ~fifo_empty_nxt | (state_d != ST_IDLE);
  end

  // All state and outputs register here.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      num_q   <= '0;
      opt_q   <= '0;
      np_q    <= 1'b0;
      op_q    <= 1'b0;
      sub_q   <= 1'b0;
      ovf_q   <= 1'b0;
      rdy_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      opt_q   <= opt_d;
      np_q    <= np_d;
      op_q    <= op_d;
      sub_q   <= sub_d;
      ovf_q   <= ovf_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
    end
  end

  assign key_ready  = rdy_q;
  assign overflow   = ovf_q;
  assign busy       = busy_q;
  assign num        = num_q;
  assign numPressed = np_q;
  assign opt        = opt_q;
  assign optPressed = op_q;
  assign submit     = sub_q;

endmodule
